// File: rtl/serial_adder_ctrl_pkg.sv
// serial_adder_ctrl_pkg: shared state encoding and default operand size
package serial_adder_ctrl_pkg;
    localparam int DEF_WORDS = 4;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;
endpackage

// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: request/result bundle between a requester and the sequencer
interface serial_adder_ctrl_if #(parameter int WORDS = serial_adder_ctrl_pkg::DEF_WORDS);
    localparam int N = 8 * WORDS;
    logic         start;
    logic         sub;
    logic         cin;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] s;
    logic         cout;
    logic         ovf;
    modport master (output start, sub, cin, a, b, input busy, done, s, cout, ovf);
    modport slave (input start, sub, cin, a, b, output busy, done, s, cout, ovf);
endinterface

// File: rtl/eightBit_ripple_adder.sv
// eightBit_ripple_adder: 8-bit ripple-carry adder built from full-adder cells
module eightBit_ripple_adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic [8:0] c;
    assign c[0] = cin;
    for (genvar g = 0; g < 8; g++) begin : g_fa
        assign sum[g]   = a[g] ^ b[g] ^ c[g];
        assign c[g + 1] = (a[g] & b[g]) | (c[g] & (a[g] ^ b[g]));
    end
    assign cout = c[8];
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: byte-serial multi-precision add/subtract around one 8-bit ripple adder
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WORDS = serial_adder_ctrl_pkg::DEF_WORDS
) (
    input logic               clk,
    input logic               reset,
    serial_adder_ctrl_if.slave bus
);
    localparam int N  = 8 * WORDS;
    localparam int IW = $clog2(WORDS);
    state_t          state, nxt;
    logic [N-1:0]    a_r, b_r, s_r;
    logic            carry_r, cout_r, ovf_r;
    logic [IW-1:0]   idx;
    logic [IW+2:0]   base;
    logic [7:0]      sum;
    logic            co;
    logic            last;
    assign base = {idx, 3'b000};
    assign last = idx == IW'(WORDS - 1);
    eightBit_ripple_adder u_add (
        .a    (a_r[base +: 8]),
        .b    (b_r[base +: 8]),
        .cin  (carry_r),
        .sum  (sum),
        .cout (co)
    );
    always_ff @(posedge clk) state <= reset ? IDLE : nxt;
    always_comb begin
        nxt = IDLE;
        nxt = state == IDLE ? (bus.start ? RUN : IDLE) :
              state == RUN  ? (last ? FIN : RUN) : IDLE;
    end
    // subtraction is A + ~B + 1, so B is inverted once at latch time
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r     <= '0;
            b_r     <= '0;
            s_r     <= '0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            idx     <= '0;
        end else if (state == IDLE && bus.start) begin
            a_r     <= bus.a;
            b_r     <= bus.sub ? ~bus.b : bus.b;
            carry_r <= bus.sub | bus.cin;
            idx     <= '0;
        end else if (state == RUN) begin
            s_r[base +: 8] <= sum;
            carry_r        <= co;
            idx            <= last ? '0 : idx + 1'b1;
            if (last) begin
                cout_r <= co;
                ovf_r  <= (a_r[N-1] == b_r[N-1]) && (sum[7] != a_r[N-1]);
            end
        end
    end
    assign bus.busy = state == RUN;
    assign bus.done = state == FIN;
    assign bus.s    = s_r;
    assign bus.cout = cout_r;
    assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed and random operations checked against an arithmetic model
module tb_serial_adder_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   n_assert = 0;
    int   n_fail = 0;
    serial_adder_ctrl_if #(.WORDS(4)) bus ();
    serial_adder_ctrl #(.WORDS(4)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [31:0] a, input logic [31:0] b, input bit sub, input bit cin,
                         output logic [31:0] s, output logic c, output logic o);
        logic [32:0] full;
        full = sub ? {1'b0, a} + {1'b0, ~b} + 33'd1 : {1'b0, a} + {1'b0, b} + {32'd0, cin};
        s = full[31:0];
        c = full[32];
        o = sub ? (a[31] != b[31]) && (s[31] != a[31]) : (a[31] == b[31]) && (s[31] != a[31]);
    endtask

    // called at #1 after the edge that accepted START; returns at #1 after the edge following DONE
    task automatic wait_result(input logic [31:0] es, input logic ec, input logic eo);
        for (int i = 0; i < 4; i++) begin
            chk("busy_run", bus.busy, 1);
            chk("done_run", bus.done, 0);
            @(posedge clk); #1;
        end
        chk("busy_fin", bus.busy, 0);
        chk("done_fin", bus.done, 1);
        chk("s", bus.s, es);
        chk("cout", bus.cout, ec);
        chk("ovf", bus.ovf, eo);
        @(posedge clk); #1;
        chk("done_pulse_end", bus.done, 0);
        chk("busy_idle", bus.busy, 0);
        chk("s_held", bus.s, es);
    endtask

    task automatic op(input logic [31:0] a, input logic [31:0] b, input bit sub, input bit cin, input bit hold);
        logic [31:0] es, js;
        logic        ec, eo, jc, jo;
        model(a, b, sub, cin, es, ec, eo);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.sub = sub;
        bus.cin = cin;
        @(posedge clk); #1;
        if (hold) begin
            bus.a = $urandom;
            bus.b = $urandom;
            bus.sub = 1'($urandom_range(1));
            bus.cin = 1'($urandom_range(1));
        end else
            bus.start = 1'b0;
        wait_result(es, ec, eo);
        if (hold) begin
            model(bus.a, bus.b, bus.sub, bus.cin, js, jc, jo);
            @(posedge clk); #1;
            bus.start = 1'b0;
            wait_result(js, jc, jo);
        end
    endtask

    initial begin
        logic [31:0] es;
        logic        ec, eo;
        reset = 1'b1;
        bus.start = 1'b1;
        bus.sub = 1'b0;
        bus.cin = 1'b0;
        bus.a = 32'h1;
        bus.b = 32'h1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_s", bus.s, 0);
        chk("rst_cout", bus.cout, 0);
        chk("rst_ovf", bus.ovf, 0);
        bus.start = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", bus.busy, 0);
        op(32'hFFFFFFFF, 32'h00000001, 0, 0, 0);
        op(32'h12345678, 32'h11111111, 0, 1, 0);
        op(32'h00000005, 32'h00000007, 1, 1, 0);
        op(32'h7FFFFFFF, 32'h00000001, 0, 0, 0);
        op(32'h80000000, 32'h00000001, 1, 0, 0);
        op(32'hCAFEBABE, 32'h0F0F0F0F, 0, 1, 1);
        // abort in the second RUN cycle
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 32'h89ABCDEF;
        bus.b = 32'h76543210;
        bus.sub = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy_before", bus.busy, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_s", bus.s, 0);
        chk("abort_cout", bus.cout, 0);
        chk("abort_ovf", bus.ovf, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("abort_no_done", bus.done, 0);
        end
        op(32'h89ABCDEF, 32'h76543210, 0, 0, 0);
        for (int i = 0; i < 25; i++)
            op($urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)), i % 8 == 3);
        model(32'h0, 32'h0, 1, 0, es, ec, eo);
        op(32'h0, 32'h0, 1, 0, 0);
        chk("sub_zero_cout", bus.cout, ec);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Byte-serial multi-precision add/subtract sequencer built around one instance of the team's 8-bit ripple-carry adder. Operands are latched on a start pulse and fed to the adder one byte per cycle, least-significant byte first. The carry is held in a register between bytes, and the full-width result is assembled in an output register. The block lets narrow adder hardware serve wide (default 32-bit) arithmetic in the datapath.

## Interface
- WORDS, 4, number of 8-bit bytes per operand (legal range 2..16); operand width N = 8*WORDS
- CLK  input  1  single clock; all state updates on rising edge
- RESET  input  1  synchronous, active-high reset
- START  input  1  request; sampled only in IDLE
- SUB  input  1  0 = A+B+CIN, 1 = A-B (sampled with START)
- CIN  input  1  carry-in for add; ignored when SUB=1
- A  input  N  operand A, sampled with START
- B  input  N  operand B, sampled with START
- BUSY  output  1  high in RUN state
- DONE  output  1  one-cycle pulse when result valid
- S  output  N  result register, held until next completion
- COUT  output  1  final carry out; for SUB = NOT borrow
- OVF  output  1  signed two's-complement overflow of the full-width result

## Operation
- States: IDLE, RUN, FIN; encoding fixed in shared constants.
- IDLE + START=1:
  - latch A into a_r; latch B into b_r, or ~B when SUB=1
  - carry_r <= (SUB ? 1 : CIN); idx <= 0; go to RUN
- IDLE + START=0: hold all state.
- RUN, every cycle:
  - adder inputs = a_r byte[idx], b_r byte[idx], carry_r
  - S byte[idx] <= adder sum; carry_r <= adder COUT; idx <= idx+1
  - if idx == WORDS-1: go to FIN; COUT <= adder COUT; OVF <= (a_r[N-1] == b_r[N-1]) && (sum[7] != a_r[N-1])
- FIN: DONE=1 for exactly this cycle, then unconditionally go to IDLE.
- START in RUN or FIN is ignored. It is not queued.
- S is written byte-wise during RUN. Its value is only guaranteed while DONE=1 and afterwards, until the next START is accepted.
- Width rules:
  - idx is ceil(log2(WORDS)) bits; it never wraps past WORDS-1
  - all arithmetic is modulo 2^N; carry beyond bit N-1 appears only on COUT
- Reset values: state=IDLE, BUSY=0, DONE=0, S=0, COUT=0, OVF=0, idx=0, carry_r=0, a_r=b_r=0.
- RESET mid-operation aborts immediately. Nothing is completed and DONE does not pulse.

## Timing
- Edge 0 accepts START.
- Edges 1..WORDS process bytes 0..WORDS-1. BUSY is high in the WORDS cycles following edge 0.
- DONE is high in the cycle after edge WORDS. For WORDS=4, DONE is seen in the 5th cycle after START was sampled.
- Next START is accepted at edge WORDS+2 at the earliest. Throughput is one operation per WORDS+2 cycles.
- Adder path is combinational within one cycle: byte select mux → 8-bit ripple → S/carry registers.
- RESET and START asserted on the same edge: RESET wins.

## Structure
- Shared package/include holds:
  - state encodings IDLE=2'd0, RUN=2'd1, FIN=2'd2
  - default WORDS constant
- One sub-module: eightBit_ripple_adder, instantiated once. It is not modified.
- Byte select and byte write-back are plain indexed part-selects on a_r/b_r/S. No extra modules.

## Test plan
All scenarios use WORDS=4.
- 0xFFFFFFFF + 0x00000001, CIN=0, SUB=0 → S=0x00000000, COUT=1, OVF=0; DONE exactly 5 cycles after START edge, BUSY high 4 cycles.
- 0x12345678 + 0x11111111, CIN=1 → S=0x2345678A, COUT=0, OVF=0; carry chain crosses byte 0→1 correctly.
- SUB=1: 0x00000005 − 0x00000007 → S=0xFFFFFFFE, COUT=0 (borrow), OVF=0; CIN=1 applied externally is ignored.
- 0x7FFFFFFF + 0x00000001 → S=0x80000000, OVF=1, COUT=0. SUB with 0x80000000 − 0x00000001 → S=0x7FFFFFFF, OVF=1, COUT=1.
- START re-asserted every cycle while BUSY and while DONE → ignored, single DONE pulse, result unchanged. Next accepted START is 2 cycles after last RUN cycle.
- RESET asserted at 2nd RUN cycle → next cycle all outputs zero, state IDLE, no DONE. A fresh START afterwards completes correctly.
